// File: rtl/soc_ctrl_rst_seq_pkg.sv
// rtl/soc_ctrl_rst_seq_pkg.sv - shared state encoding and helpers for the SoC domain power sequencer
package soc_ctrl_rst_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    UP_RST,
    UP_HOLD,
    UP_ACK,
    UP_GAP,
    ON,
    DN_CLK,
    DN_ACK,
    DN_GAP,
    ERR
  } rst_seq_state_e;

  localparam int MAX_DOMAINS = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soc_ctrl_rst_seq_timer.sv
// rtl/soc_ctrl_rst_seq_timer.sv - loadable down-counter with zero flag, saturating at 0
module soc_ctrl_rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/soc_ctrl_rst_seq.sv
// rtl/soc_ctrl_rst_seq.sv - ordered per-domain reset/clock power sequencer
// Optional ack timeout and ERR state: SOC_CTRL_RST_SEQ_TIMEOUT_EN
module soc_ctrl_rst_seq
  import soc_ctrl_rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 3,
  parameter int RST_HOLD_CYCLES = 8,
  parameter int GAP_CYCLES      = 4,
  parameter int ACK_TIMEOUT     = 64,
  localparam int IDX_W          = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [NUM_DOMAINS-1:0] dom_ack_i,
  output logic [NUM_DOMAINS-1:0] dom_arst_no,
  output logic [NUM_DOMAINS-1:0] dom_clk_en_o,
  output logic [IDX_W-1:0]       cur_dom_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int TW = $clog2(max3(RST_HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
`endif

  rst_seq_state_e   r_state, w_nstate;
  logic [IDX_W-1:0] r_idx, w_nidx;
  logic             w_load, w_dec, w_zero;
  logic [TW-1:0]    w_load_val;
  logic             w_arst_set, w_arst_clr, w_clk_set, w_clk_clr, w_all_off;

  soc_ctrl_rst_seq_timer #(.W(TW)) u_timer (
    .i_clk      (clk_i),
    .i_rst      (arst_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_nstate   = r_state;
    w_nidx     = r_idx;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    w_arst_set = 1'b0;
    w_arst_clr = 1'b0;
    w_clk_set  = 1'b0;
    w_clk_clr  = 1'b0;
    w_all_off  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !stop_i) begin
          w_nstate = UP_RST;
          w_nidx   = '0;
        end
      end
      UP_RST, UP_HOLD, UP_ACK, UP_GAP: begin
        if (stop_i) begin
          w_nstate = DN_CLK;
        end else if (r_state == UP_RST) begin
          w_arst_set = 1'b1;
          w_load     = 1'b1;
          w_load_val = HOLD_LOAD;
          w_nstate   = UP_HOLD;
        end else if (r_state == UP_HOLD) begin
          if (w_zero) begin
            w_clk_set = 1'b1;
            w_nstate  = UP_ACK;
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
            w_load     = 1'b1;
            w_load_val = ACK_LOAD;
`endif
          end else begin
            w_dec = 1'b1;
          end
        end else if (r_state == UP_ACK) begin
          if (dom_ack_i[r_idx]) begin
            if (r_idx == LAST_IDX) begin
              w_nstate = ON;
            end else begin
              w_nidx     = r_idx + 1'b1;
              w_load     = 1'b1;
              w_load_val = GAP_LOAD;
              w_nstate   = UP_GAP;
            end
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
          end else if (w_zero) begin
            w_nstate  = ERR;
            w_all_off = 1'b1;
          end else begin
            w_dec = 1'b1;
`endif
          end
        end else begin
          // gap expiry releases the next reset directly so the gap is exactly GAP_CYCLES
          if (w_zero) begin
            w_arst_set = 1'b1;
            w_load     = 1'b1;
            w_load_val = HOLD_LOAD;
            w_nstate   = UP_HOLD;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ON: begin
        if (stop_i) begin
          w_nstate = DN_CLK;
          w_nidx   = LAST_IDX;
        end
      end
      DN_CLK: begin
        if (!dom_arst_no[r_idx]) begin
          if (r_idx == '0) w_nstate = IDLE;
          else             w_nidx   = r_idx - 1'b1;
        end else begin
          w_clk_clr = 1'b1;
          w_nstate  = DN_ACK;
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
          w_load     = 1'b1;
          w_load_val = ACK_LOAD;
`endif
        end
      end
      DN_ACK: begin
        if (!dom_ack_i[r_idx]) begin
          w_arst_clr = 1'b1;
          if (r_idx == '0) begin
            w_nstate = IDLE;
          end else begin
            w_nidx     = r_idx - 1'b1;
            w_load     = 1'b1;
            w_load_val = GAP_LOAD;
            w_nstate   = DN_GAP;
          end
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
        end else if (w_zero) begin
          w_nstate  = ERR;
          w_all_off = 1'b1;
        end else begin
          w_dec = 1'b1;
`endif
        end
      end
      DN_GAP: begin
        if (w_zero) begin
          w_clk_clr = 1'b1;
          w_nstate  = DN_ACK;
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
          w_load     = 1'b1;
          w_load_val = ACK_LOAD;
`endif
        end else begin
          w_dec = 1'b1;
        end
      end
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
      ERR: begin
        if (stop_i) begin
          w_nstate = IDLE;
          w_nidx   = '0;
        end
      end
`endif
      default: begin
        w_nstate = IDLE;
        w_nidx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      dom_arst_no  <= '0;
      dom_clk_en_o <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      if (w_all_off) begin
        dom_arst_no  <= '0;
        dom_clk_en_o <= '0;
      end else begin
        if (w_arst_set) dom_arst_no[r_idx]  <= 1'b1;
        if (w_arst_clr) dom_arst_no[r_idx]  <= 1'b0;
        if (w_clk_set)  dom_clk_en_o[r_idx] <= 1'b1;
        if (w_clk_clr)  dom_clk_en_o[r_idx] <= 1'b0;
      end
    end
  end

  assign cur_dom_o = r_idx;
  assign done_o    = (r_state == ON);
  assign busy_o    = (r_state != IDLE) && (r_state != ON) && (r_state != ERR);
`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
  assign err_o = (r_state == ERR);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_soc_ctrl_rst_seq.sv
// tb/tb_soc_ctrl_rst_seq.sv - scoreboard bench for the domain power sequencer
module tb_soc_ctrl_rst_seq;

  localparam int ND = 3;

  logic          clk_i = 1'b0;
  logic          arst_i, start_i, stop_i;
  logic [ND-1:0] dom_ack_i, dom_arst_no, dom_clk_en_o;
  logic [1:0]    cur_dom_o;
  logic          busy_o, done_o, err_o;

  soc_ctrl_rst_seq #(
    .NUM_DOMAINS(ND), .RST_HOLD_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .stop_i(stop_i),
    .dom_ack_i(dom_ack_i), .dom_arst_no(dom_arst_no), .dom_clk_en_o(dom_clk_en_o),
    .cur_dom_o(cur_dom_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // ack model: clock enable echoed back three cycles later, per-domain blockable
  logic [ND-1:0] r_a1 = '0, r_a2 = '0, r_a3 = '0, ack_block = '0;
  always @(posedge clk_i) begin
    r_a1 <= dom_clk_en_o;
    r_a2 <= r_a1;
    r_a3 <= r_a2;
  end
  assign dom_ack_i = r_a3 & ~ack_block;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // tuple = {arst[2:0], clk_en[2:0], busy, done, err, cur[1:0]}
  typedef struct {
    logic [10:0] v;
    int          dly;
  } exp_t;
  exp_t sb[$];

  logic [10:0] up_v [10] = '{
    11'b000_000_1_0_0_00, 11'b001_000_1_0_0_00, 11'b001_001_1_0_0_00,
    11'b001_001_1_0_0_01, 11'b011_001_1_0_0_01, 11'b011_011_1_0_0_01,
    11'b011_011_1_0_0_10, 11'b111_011_1_0_0_10, 11'b111_111_1_0_0_10,
    11'b111_111_0_1_0_10};
  int up_d [10] = '{1, 1, 4, 4, 2, 4, 4, 2, 4, 4};
  logic [10:0] dn_v [7] = '{
    11'b111_111_1_0_0_10, 11'b111_011_1_0_0_10, 11'b011_011_1_0_0_01,
    11'b011_001_1_0_0_01, 11'b001_001_1_0_0_00, 11'b001_000_1_0_0_00,
    11'b000_000_0_0_0_00};
  int dn_d [7] = '{1, 1, 4, 2, 4, 2, 4};

  int errors = 0, checks = 0, last_cyc = 0;
  logic [10:0] prev;

  function automatic logic [10:0] snap();
    return {dom_arst_no, dom_clk_en_o, busy_o, done_o, err_o, cur_dom_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [10:0] v, input int dly);
    exp_t e;
    e.v   = v;
    e.dly = dly;
    sb.push_back(e);
  endtask

  task automatic push_up(input int n);
    for (int i = 0; i < n; i++) push(up_v[i], up_d[i]);
  endtask

  task automatic push_dn();
    for (int i = 0; i < 7; i++) push(dn_v[i], dn_d[i]);
  endtask

  task automatic step(input int n);
    logic [10:0] cur;
    exp_t        e;
    repeat (n) begin
      @(negedge clk_i);
      cur = snap();
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_change", {21'd0, cur}, {21'd0, prev});
        end else begin
          e = sb.pop_front();
          chk("outputs", {21'd0, cur}, {21'd0, e.v});
          chk("delay", cyc - last_cyc, e.dly);
        end
        last_cyc = cyc;
        prev     = cur;
      end
    end
  endtask

  task automatic mark();
    last_cyc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_state", {21'd0, snap()}, 32'd0);
    arst_i = 1'b0;
    prev = snap();

    // 1: full power-up
    start_i = 1'b1; mark(); push_up(10);
    step(1); start_i = 1'b0;
    step(34);
    chk("t1_drained", sb.size(), 0);

    // 2: power-down from ON
    stop_i = 1'b1; mark(); push_dn();
    step(1); stop_i = 1'b0;
    step(22);
    chk("t2_drained", sb.size(), 0);

    // 3: abort while domain 1 is in its reset hold
    start_i = 1'b1; mark(); push_up(5);
    step(1); start_i = 1'b0;
    for (int n = 0; n < 30 && dom_arst_no !== 3'b011; n++) step(1);
    chk("t3_reach_hold", {29'd0, dom_arst_no}, 32'b011);
    stop_i = 1'b1; mark();
    push(11'b001_001_1_0_0_00, 3);
    push(11'b001_000_1_0_0_00, 2);
    push(11'b000_000_0_0_0_00, 4);
    step(1); stop_i = 1'b0;
    step(12);
    chk("t3_drained", sb.size(), 0);

    // 4: start and stop together in IDLE
    start_i = 1'b1; stop_i = 1'b1;
    step(20);
    start_i = 1'b0; stop_i = 1'b0;
    chk("t4_idle", {21'd0, snap()}, 32'd0);

    // 5: async reset while domain 2 awaits ack, then clean restart
    start_i = 1'b1; mark(); push_up(9);
    step(1); start_i = 1'b0;
    for (int n = 0; n < 40 && dom_clk_en_o !== 3'b111; n++) step(1);
    chk("t5_reach_ack", {30'd0, cur_dom_o}, 32'd2);
    #2 arst_i = 1'b1;
    #1 chk("t5_async_rst", {21'd0, snap()}, 32'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    prev = snap();
    step(6);
    start_i = 1'b1; mark(); push_up(10);
    step(1); start_i = 1'b0;
    step(34);
    chk("t5_restart", sb.size(), 0);
    stop_i = 1'b1; mark(); push_dn();
    step(1); stop_i = 1'b0;
    step(22);
    chk("t5_down", sb.size(), 0);

`ifdef SOC_CTRL_RST_SEQ_TIMEOUT_EN
    // 6: domain 1 ack never arrives
    ack_block = 3'b010;
    start_i = 1'b1; mark(); push_up(6);
    push(11'b000_000_0_0_1_01, 16);
    step(1); start_i = 1'b0;
    step(35);
    chk("t6_err", {31'd0, err_o}, 32'd1);
    stop_i = 1'b1; mark();
    push(11'b000_000_0_0_0_00, 1);
    step(1); stop_i = 1'b0;
    step(3);
    ack_block = 3'b000;
    chk("t6_drained", sb.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
